// File: rtl/pdm_capture_dump.sv
// PDM microphone capture buffer with UART dumper (ASCII '0'/'1' or packed hex, then CR LF).
// Start latency: busy rises after the dump edge; the first start bit (tx=0) follows one clk later.
module pdm_capture_dump #(
    parameter int PDM_DIV   = 12,
    parameter int BAUD_DIV  = 1250,
    parameter int DEPTH     = 128,
    parameter int STOP_BITS = 1,
    parameter int HEX_MODE  = 0
) (
    input  logic clk,
    input  logic rst,
    output logic pdm_clk,
    input  logic pdm_dat,
    input  logic arm,
    input  logic dump,
    output logic tx,
    output logic capturing,
    output logic full,
    output logic busy
);
    localparam int AW     = $clog2(DEPTH);
    localparam int NDATA  = (HEX_MODE != 0) ? DEPTH / 4 : DEPTH;
    localparam int NCHARS = NDATA + 2;
    localparam int CW     = $clog2(NCHARS + 1);
    localparam int PW     = $clog2(PDM_DIV);
    localparam int BDW    = $clog2(BAUD_DIV);

    localparam logic [PW-1:0]  PDM_LAST   = PW'(PDM_DIV - 1);
    localparam logic [PW-1:0]  PDM_HALF   = PW'(PDM_DIV / 2);
    localparam logic [BDW-1:0] BAUD_LAST  = BDW'(BAUD_DIV - 1);
    localparam logic [3:0]     FRAME_LAST = 4'(9 + STOP_BITS - 1);
    localparam logic [AW:0]    DEPTH_CNT  = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0]  CHARS_END  = CW'(NCHARS);
    localparam logic [AW+1:0]  CR_IDX     = (AW + 2)'(NDATA);
    localparam logic [AW+1:0]  LF_IDX     = (AW + 2)'(NDATA + 1);

    typedef enum logic [1:0] {IDLE, CAPTURE, FULL, DUMP} state_t;
    state_t state, state_nx;

    logic [PW-1:0]    pdm_cnt;
    logic             pdm_rise;
    logic [AW:0]      scnt;
    logic             wr_en;
    logic [DEPTH-1:0] samples;
    logic [BDW-1:0]   baud_cnt;
    logic [3:0]       bit_idx;
    logic [CW-1:0]    char_idx;
    logic [AW+1:0]    cidx;
    logic [AW-1:0]    nbase;
    logic [3:0]       nib;
    logic [7:0]       chr;
    logic             frame_bit;
    logic             dump_done;

    assign capturing = (state == CAPTURE);
    assign full      = (state == FULL) || (state == DUMP);
    assign busy      = (state == DUMP);

    // pdm_clk is about to register 0->1: this edge is a sample event
    assign pdm_rise  = !pdm_clk && (pdm_cnt < PDM_HALF);
    assign wr_en     = (state == CAPTURE) && pdm_rise && !scnt[AW];
    assign dump_done = (char_idx == CHARS_END);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (arm) state_nx = CAPTURE;
            CAPTURE: if (scnt == DEPTH_CNT) state_nx = FULL;
            FULL:    if (arm) state_nx = CAPTURE;
                     else if (dump) state_nx = DUMP;
            DUMP:    if (dump_done) state_nx = FULL;
            default: state_nx = IDLE;
        endcase
    end

    // Character currently being framed: data chars, then CR, then LF
    always_comb begin
        cidx  = (AW + 2)'(char_idx);
        nbase = {cidx[AW-3:0], 2'b00};
        nib   = {samples[nbase], samples[nbase | AW'(1)],
                 samples[nbase | AW'(2)], samples[nbase | AW'(3)]};
        if (cidx == CR_IDX)        chr = 8'h0D;
        else if (cidx == LF_IDX)   chr = 8'h0A;
        else if (HEX_MODE != 0)    chr = (nib < 4'd10) ? 8'h30 + {4'h0, nib} : 8'h37 + {4'h0, nib};
        else                       chr = {7'b0011000, samples[cidx[AW-1:0]]};
        if (bit_idx == 4'd0)       frame_bit = 1'b0;
        else if (bit_idx <= 4'd8)  frame_bit = chr[3'(bit_idx - 4'd1)];
        else                       frame_bit = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_en) samples[scnt[AW-1:0]] <= pdm_dat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pdm_cnt  <= '0;
            pdm_clk  <= 1'b0;
            scnt     <= '0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            char_idx <= '0;
            tx       <= 1'b1;
        end else begin
            pdm_cnt <= (pdm_cnt == PDM_LAST) ? '0 : pdm_cnt + 1'b1;
            pdm_clk <= (pdm_cnt < PDM_HALF);

            if (state_nx == CAPTURE && state != CAPTURE) scnt <= '0;
            else if (wr_en)                              scnt <= scnt + 1'b1;

            tx <= 1'b1;
            if (state != DUMP) begin
                baud_cnt <= '0;
                bit_idx  <= '0;
                char_idx <= '0;
            end else if (!dump_done) begin
                tx <= frame_bit;
                if (baud_cnt == BAUD_LAST) begin
                    baud_cnt <= '0;
                    if (bit_idx == FRAME_LAST) begin
                        bit_idx  <= '0;
                        char_idx <= char_idx + 1'b1;
                    end else begin
                        bit_idx <= bit_idx + 1'b1;
                    end
                end else begin
                    baud_cnt <= baud_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_pdm_capture_dump.sv
// Bench for pdm_capture_dump: three configurations, table rows, random patterns vs a byte-level model.
module tb_pdm_capture_dump;
    typedef logic [7:0] u8_t;
    typedef struct {
        int         sel;
        logic [7:0] pat;
        int         nb;
        logic [79:0] want;
        int         reps;
        bit         dmid;
        bit         amid;
    } vec_t;

    localparam int P_PDM  [3] = '{12, 12, 4};
    localparam int P_BAUD [3] = '{16, 16, 4};
    localparam int P_STOP [3] = '{1, 2, 1};
    localparam int P_HEX  [3] = '{0, 1, 1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       pdm_dat = 1'b0;
    logic [2:0] arm = '0, dump = '0;
    logic [2:0] pdm_clk, tx, capturing, full, busy;

    pdm_capture_dump #(.PDM_DIV(12), .BAUD_DIV(16), .DEPTH(8), .STOP_BITS(1), .HEX_MODE(0)) u_bin (
        .clk(clk), .rst(rst), .pdm_clk(pdm_clk[0]), .pdm_dat(pdm_dat), .arm(arm[0]), .dump(dump[0]),
        .tx(tx[0]), .capturing(capturing[0]), .full(full[0]), .busy(busy[0]));
    pdm_capture_dump #(.PDM_DIV(12), .BAUD_DIV(16), .DEPTH(8), .STOP_BITS(2), .HEX_MODE(1)) u_hex (
        .clk(clk), .rst(rst), .pdm_clk(pdm_clk[1]), .pdm_dat(pdm_dat), .arm(arm[1]), .dump(dump[1]),
        .tx(tx[1]), .capturing(capturing[1]), .full(full[1]), .busy(busy[1]));
    pdm_capture_dump #(.PDM_DIV(4), .BAUD_DIV(4), .DEPTH(4096), .STOP_BITS(1), .HEX_MODE(1)) u_big (
        .clk(clk), .rst(rst), .pdm_clk(pdm_clk[2]), .pdm_dat(pdm_dat), .arm(arm[2]), .dump(dump[2]),
        .tx(tx[2]), .capturing(capturing[2]), .full(full[2]), .busy(busy[2]));

    int   n_chk = 0, n_pass = 0;
    int   busy_len;
    logic txq[$];

    task automatic chk(input string name, input bit ok, input longint got, input longint want);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    endtask

    task automatic chk_eq(input string name, input longint got, input longint want);
        chk(name, got == want, got, want);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pat_q(input logic [7:0] pat, output bit q[$]);
        q.delete();
        for (int i = 7; i >= 0; i--) q.push_back(pat[i]);
    endtask

    // Expected characters straight from the sample list
    task automatic model_bytes(input int s, input bit q[$], output u8_t r[$]);
        int v;
        r.delete();
        if (P_HEX[s] != 0) begin
            for (int k = 0; k < q.size() / 4; k++) begin
                v = 8 * int'(q[4*k]) + 4 * int'(q[4*k+1]) + 2 * int'(q[4*k+2]) + int'(q[4*k+3]);
                r.push_back(v < 10 ? u8_t'(48 + v) : u8_t'(65 + v - 10));
            end
        end else begin
            foreach (q[k]) r.push_back(q[k] ? 8'h31 : 8'h30);
        end
        r.push_back(8'h0D);
        r.push_back(8'h0A);
    endtask

    task automatic wait_full(input int s);
        int g = 0;
        while (!full[s] && g < 5000 * P_PDM[s]) begin tick; g++; end
        chk_eq("capture completes", full[s], 1);
    endtask

    task automatic do_capture(input int s, input bit q[$], input bit dmid);
        bit prev;
        int idx = 0, guard = 0;
        pdm_dat = q[0];
        arm[s] = 1'b1; tick; arm[s] = 1'b0;
        chk_eq("arm -> capturing", capturing[s], 1);
        prev = pdm_clk[s];
        while (idx < q.size() && guard < (q.size() + 2) * P_PDM[s]) begin
            dump[s] = dmid && (guard == 20);
            tick; guard++;
            if (dmid && guard == 21) chk_eq("dump ignored in capture", {busy[s], capturing[s]}, 2'b01);
            if (pdm_clk[s] && !prev) begin
                idx++;
                if (idx < q.size()) pdm_dat = q[idx];
            end
            prev = pdm_clk[s];
        end
        dump[s] = 1'b0;
        pdm_dat = ~q[0];
        chk_eq("sample events seen", idx, q.size());
        chk_eq("still capturing at last sample", {capturing[s], full[s]}, 2'b10);
        tick;
        chk_eq("full one cycle after last sample", {capturing[s], full[s]}, 2'b01);
    endtask

    task automatic run_dump(input int s, input bit amid);
        int guard = 0;
        txq.delete();
        busy_len = 0;
        dump[s] = 1'b1; tick; dump[s] = 1'b0;
        while (busy[s] && guard < 60000) begin
            txq.push_back(tx[s]);
            busy_len++;
            arm[s] = amid && (busy_len == 50);
            tick; guard++;
        end
        arm[s] = 1'b0;
        chk_eq("state after dump {full,busy,capturing,tx}",
               {full[s], busy[s], capturing[s], tx[s]}, 4'b1001);
    endtask

    task automatic verify(input int s, input string tag, input u8_t eb[$]);
        int   fb, n, bad, lim;
        u8_t  gb[$];
        u8_t  v;
        logic ew[$];
        fb = (9 + P_STOP[s]) * P_BAUD[s];
        chk_eq({tag, " busy cycles"}, busy_len, eb.size() * fb + 1);
        n = (txq.size() > 0) ? (txq.size() - 1) / fb : 0;
        for (int c = 0; c < n; c++) begin
            for (int i = 0; i < 8; i++) v[i] = txq[1 + c*fb + (i+1)*P_BAUD[s] + P_BAUD[s]/2];
            gb.push_back(v);
        end
        chk_eq({tag, " char count"}, gb.size(), eb.size());
        bad = -1;
        for (int c = 0; c < gb.size() && c < eb.size(); c++)
            if (bad < 0 && gb[c] != eb[c]) bad = c;
        chk({tag, " chars"}, bad < 0, bad < 0 ? 0 : gb[bad], bad < 0 ? 0 : eb[bad]);
        ew.delete();
        ew.push_back(1'b1);
        foreach (eb[c]) begin
            repeat (P_BAUD[s]) ew.push_back(1'b0);
            for (int i = 0; i < 8; i++) repeat (P_BAUD[s]) ew.push_back(eb[c][i]);
            repeat (P_STOP[s] * P_BAUD[s]) ew.push_back(1'b1);
        end
        lim = (ew.size() < txq.size()) ? ew.size() : txq.size();
        bad = -1;
        for (int i = 0; i < lim; i++) if (bad < 0 && ew[i] != txq[i]) bad = i;
        if (bad < 0 && ew.size() != txq.size()) bad = lim;
        chk({tag, " tx waveform first diverging cycle"}, bad < 0, bad, -1);
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        bit   q[$];
        u8_t  eb[$];
        int   e0, e2;
        logic [7:0] pat;

        tbl[0] = '{0, 8'b10110010, 10, 80'h3130_3131_3030_3130_0D0A, 1, 1'b1, 1'b1};
        tbl[1] = '{1, 8'b10110010, 4,  80'h4232_0D0A,                2, 1'b0, 1'b0};
        tbl[2] = '{0, 8'h00,       10, 80'h3030_3030_3030_3030_0D0A, 1, 1'b0, 1'b0};
        tbl[3] = '{1, 8'hFF,       4,  80'h4646_0D0A,                1, 1'b0, 1'b0};
        tbl[4] = '{1, 8'h09,       4,  80'h3039_0D0A,                1, 1'b0, 1'b0};
        tbl[5] = '{1, 8'hA5,       4,  80'h4135_0D0A,                1, 1'b0, 1'b0};

        tick; tick;
        chk_eq("reset tx", tx, 3'b111);
        chk_eq("reset pdm_clk/capturing/full/busy", {pdm_clk, capturing, full, busy}, 12'h000);
        rst = 1'b0;

        // Reset in the middle of a capture, then check the divider restarts from 0
        arm[0] = 1'b1; tick; arm[0] = 1'b0;
        repeat (20) tick;
        rst = 1'b1; tick;
        chk_eq("mid-run reset tx", tx, 3'b111);
        chk_eq("mid-run reset others", {pdm_clk, capturing, full, busy}, 12'h000);
        tick; tick; rst = 1'b0;
        e0 = 0; e2 = 0;
        for (int i = 0; i < 24; i++) begin
            tick;
            if (pdm_clk[0] != ((i % 12) < 6)) e0++;
            if (pdm_clk[2] != ((i % 4) < 2)) e2++;
        end
        chk_eq("pdm_clk 6 high / 6 low errors", e0, 0);
        chk_eq("pdm_clk 2 high / 2 low errors", e2, 0);

        foreach (tbl[r]) begin
            pat_q(tbl[r].pat, q);
            do_capture(tbl[r].sel, q, tbl[r].dmid);
            eb.delete();
            for (int i = 0; i < tbl[r].nb; i++) eb.push_back(tbl[r].want[(tbl[r].nb - 1 - i) * 8 +: 8]);
            for (int k = 0; k < tbl[r].reps; k++) begin
                run_dump(tbl[r].sel, tbl[r].amid && k == 0);
                verify(tbl[r].sel, $sformatf("row%0d dump%0d", r, k), eb);
            end
        end

        for (int r = 0; r < 3; r++) begin
            for (int s = 0; s < 2; s++) begin
                pat = 8'($urandom_range(0, 255));
                pat_q(pat, q);
                do_capture(s, q, 1'b0);
                run_dump(s, 1'b0);
                model_bytes(s, q, eb);
                verify(s, $sformatf("rand%0d dut%0d pat %02h", r, s, pat), eb);
            end
        end

        // arm and dump together in FULL: arm wins
        arm[1] = 1'b1; dump[1] = 1'b1; tick; arm[1] = 1'b0; dump[1] = 1'b0;
        chk_eq("arm+dump in FULL {capturing,busy}", {capturing[1], busy[1]}, 2'b10);
        wait_full(1);

        // Reset during d1 (a 0 bit) of the third character
        pat_q(8'b10110010, q);
        do_capture(0, q, 1'b0);
        dump[0] = 1'b1; tick; dump[0] = 1'b0;
        repeat (361) tick;
        chk_eq("tx low in 3rd char data bit", tx[0], 0);
        rst = 1'b1; tick; rst = 1'b0;
        chk_eq("reset mid-dump {tx,busy,full}", {tx[0], busy[0], full[0]}, 3'b100);
        dump[0] = 1'b1; tick; dump[0] = 1'b0;
        chk_eq("dump after reset ignored {busy,tx}", {busy[0], tx[0]}, 2'b01);
        repeat (20) tick;
        chk_eq("still idle {busy,full,tx}", {busy[0], full[0], tx[0]}, 3'b001);
        arm[0] = 1'b1; tick; arm[0] = 1'b0;
        chk_eq("arm after reset starts capture", capturing[0], 1);
        wait_full(0);

        // Largest depth, alternating pattern
        q.delete();
        for (int i = 0; i < 4096; i++) q.push_back(i % 2 == 0);
        do_capture(2, q, 1'b0);
        repeat (12) tick;
        chk_eq("big buffer stays full {capturing,full}", {capturing[2], full[2]}, 2'b01);
        run_dump(2, 1'b0);
        model_bytes(2, q, eb);
        verify(2, "depth4096", eb);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
